alu_issue_sequencer: RTL and testbench
======================================

// Module: alu_issue_sequencer
// PURPOSE
//  Upstream issue stage for the 16-bit ALU. Accepts instruction words over a valid/ready
//  port into a small FIFO and reads operands from an internal 8x16 register file. Drives
//  the ALU operand/opcode inputs, writes the ALU result back to the register file and
//  latches the ALU flags. Executes one instruction at a time, strictly in order.
// PARAMETERS
//  FIFO_DEPTH   4   instruction FIFO entries (power of 2, >=2)
//  REG_ADDR_W   3   register-file address width (2**REG_ADDR_W regs, 16 bits each)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  reset            in   1   asynchronous, active-high reset
//  instr_valid      in   1   instruction offered
//  instr_ready      out  1   FIFO can accept (count < FIFO_DEPTH)
//  instr_data       in   32  [31:28] op, [27:25] rd, [24:22] rs1, [21:19] rs2, [18:16] rsvd, [15:0] imm
//  alu_a            out  16  ALU operand A (reg[rs1])
//  alu_b            out  16  ALU operand B (reg[rs2])
//  alu_op           out  4   ALU opcode
//  alu_q            in   16  ALU registered result
//  alu_carry_borrow in   1   ALU carry/borrow, valid with alu_q
//  alu_zero         in   1   ALU zero flag, valid one cycle after alu_q
//  alu_parity       in   1   ALU parity flag, valid one cycle after alu_q
//  busy             out  1   state != IDLE or FIFO non-empty
//  done             out  1   one-cycle pulse per retired instruction
//  flags            out  3   {carry, zero, parity} of last retired ALU instruction
//  dbg_addr         in   3   register-file debug read address
//  dbg_data         out  16  reg[dbg_addr], combinational
// BEHAVIOUR
//  Reset: FIFO emptied, all regs 0, state IDLE, alu_a=alu_b=0, alu_op=4'b1111 (ALU NOP,
//   result 0), flags=0, done=0, busy=0, instr_ready=1 the cycle after release.
//  FIFO: push when instr_valid & instr_ready; instr_ready from registered count only, so a
//   pop in the same cycle does not raise it. Pop reads only the registered count; an entry
//   pushed into an empty FIFO is poppable the next cycle. Pointers wrap mod FIFO_DEPTH.
//  FSM: IDLE -> ISSUE -> WB -> FLAGS -> IDLE.
//   IDLE: if FIFO non-empty, pop the head.
//     op==4'b1111 (LDI): reg[rd] <= imm at that edge; done pulses next cycle; stay in IDLE.
//     else: register alu_a<=reg[rs1], alu_b<=reg[rs2], alu_op<=op; go to ISSUE.
//   ISSUE: operands stable; the ALU samples them at the end of this cycle.
//   WB: alu_q valid; reg[rd] <= alu_q and carry latch <= alu_carry_borrow at end of cycle.
//   FLAGS: flags <= {carry latch, alu_zero, alu_parity} at end of cycle; done pulses the
//     following cycle; alu_op <= 4'b1111; alu_a and alu_b hold their last values.
//  alu_a/b/op are held constant from ISSUE through FLAGS, so ALU re-evaluation is stable.
//  Ops 1010..1110 issue normally; the ALU returns 0, which is written back.
//  Latency: ALU instruction takes 4 cycles from the pop edge to the done pulse. LDI takes
//   1 cycle. Back-to-back ALU instructions retire one per 4 cycles.
//  rd==rs1/rs2: operands are read at pop, so the pre-write value is used. No hazards,
//   because instructions are serial. The write to r0 is a normal register write.
//  Reset mid-operation (any state): in-flight instruction aborted, no writeback, no done,
//   all state returns to reset values.
// TESTING
//  LDI r1=0x0005, LDI r2=0x0003, ADD(0000) r3=r1+r2 -> r3=0x0008, flags=3'b000, 3 done pulses.
//  SUB(0001) r4=r2-r1 -> r4=0xFFFE, flags={1,0,0}; done 4 cycles after pop.
//  LDI r5=0xFFFF, LDI r6=0x0001, ADD r7=r5+r6 -> r7=0x0000, flags={1,1,1}.
//  Push 6 ADDs on consecutive cycles from reset -> instr_ready low whenever count==4; none
//   lost; 6 done pulses, results in order; busy low after the last done.
//  Assert reset during WB of SUB r4 -> r4 stays 0, no done, alu_op=4'b1111, instr_ready=1.
//  NOT(1001) r2=~r1, rd==rs1 case r1=~r1 -> uses pre-write r1; dbg_data(r1)=~old r1.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
// Issue stage for the 16-bit ALU: instruction FIFO, register file and a serial
// IDLE/ISSUE/WB/FLAGS sequencer that drives the ALU and retires its results.
module alu_issue_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr_data,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [3:0]            alu_op,
    input  logic [15:0]           alu_q,
    input  logic                  alu_carry_borrow,
    input  logic                  alu_zero,
    input  logic                  alu_parity,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            flags,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [15:0]           dbg_data
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [3:0] OP_NOP_LDI = 4'b1111;

    typedef enum logic [1:0] {IDLE, ISSUE, WB, FLAGS} state_t;

    state_t                state;
    logic [28:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic                  rsvd_unused;

    logic [28:0]           head;
    logic [3:0]            head_op;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [REG_ADDR_W-1:0] head_rs1;
    logic [REG_ADDR_W-1:0] head_rs2;
    logic [15:0]           head_imm;

    logic [15:0]           regs [NUM_REGS];
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  carry_q;

    // The reserved field is dropped before storage; only op, rd, rs1, rs2 and imm are queued.
    assign rsvd_unused = ^instr_data[18:16];

    assign instr_ready = count < CNT_W'(FIFO_DEPTH);
    assign push        = instr_valid && instr_ready;
    assign pop         = (state == IDLE) && (count != '0);
    assign busy        = (state != IDLE) || (count != '0);
    assign dbg_data    = regs[dbg_addr];

    assign head     = fifo_mem[rd_ptr];
    assign head_op  = head[28:25];
    assign head_rd  = head[24 -: REG_ADDR_W];
    assign head_rs1 = head[21 -: REG_ADDR_W];
    assign head_rs2 = head[18 -: REG_ADDR_W];
    assign head_imm = head[15:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {instr_data[31:19], instr_data[15:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Operands are captured at pop and held through FLAGS so the ALU's
    // delayed zero/parity flags see the same inputs as its result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= OP_NOP_LDI;
            flags   <= '0;
            done    <= 1'b0;
            rd_q    <= '0;
            carry_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_op == OP_NOP_LDI) begin
                            regs[head_rd] <= head_imm;
                            done          <= 1'b1;
                        end else begin
                            alu_a  <= regs[head_rs1];
                            alu_b  <= regs[head_rs2];
                            alu_op <= head_op;
                            rd_q   <= head_rd;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WB;
                end
                WB: begin
                    regs[rd_q] <= alu_q;
                    carry_q    <= alu_carry_borrow;
                    state      <= FLAGS;
                end
                FLAGS: begin
                    flags  <= {carry_q, alu_zero, alu_parity};
                    done   <= 1'b1;
                    alu_op <= OP_NOP_LDI;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: behavioural ALU, directed scenarios and random
// instruction traffic checked against a queue-based in-order retirement model.
module tb_alu_issue_sequencer;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_q;
    logic        alu_carry_borrow;
    logic        alu_zero;
    logic        alu_parity;
    logic        busy;
    logic        done;
    logic [2:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_issue_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .REG_ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_q(alu_q), .alu_carry_borrow(alu_carry_borrow), .alu_zero(alu_zero),
        .alu_parity(alu_parity), .busy(busy), .done(done), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU definition: returns {carry/borrow, result}.
    function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h0:    return {1'b0, a} + {1'b0, b};
            4'h1:    return {(a < b), a - b};
            4'h2:    return {1'b0, a & b};
            4'h3:    return {1'b0, a | b};
            4'h4:    return {1'b0, a ^ b};
            4'h5:    return {a[15], a << 1};
            4'h6:    return {a[0], a >> 1};
            4'h7:    return {1'b0, a} + 17'd1;
            4'h8:    return {(a == 16'h0), a - 16'd1};
            4'h9:    return {1'b0, ~a};
            default: return 17'd0;
        endcase
    endfunction

    // Registered ALU: result and carry one cycle after operands, zero/parity one cycle later.
    always_ff @(posedge clk) begin
        {alu_carry_borrow, alu_q} <= alu_fn(alu_op, alu_a, alu_b);
        alu_zero                  <= (alu_q == 16'h0);
        alu_parity                <= ~^alu_q;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          edge_n = 0;
    int          ret_edge = -1;
    int          busy_until = -1;
    int          free_edge = 0;
    int          pop_e = -1;
    int          done_seen = 0;
    logic [3:0]  cur_op;
    logic        ret_alu;
    logic [2:0]  ret_rd;
    logic [15:0] ret_val;
    logic [2:0]  mflags;
    logic [2:0]  pend_flags;
    logic [15:0] mregs [8];
    logic [31:0] pend [$];
    logic [31:0] send_q [$];
    bit          rand_mode;
    bit          saw_ready_low;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, 3'b000, imm};
    endfunction

    task automatic applyStimulus(input logic [31:0] instr);
        send_q.push_back(instr);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) < 4) w[31:28] = 4'hF;
        else                          w[31:28] = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 7) == 0) w[15:0] = 16'hFFFF;
        return w;
    endfunction

    // Reference retirement: each instruction pops when the sequencer is free,
    // LDI retires at its pop edge, an ALU op retires three edges later.
    task automatic retire_model(input logic [31:0] instr);
        logic [16:0] r;
        logic [3:0]  op;
        op     = instr[31:28];
        ret_rd = instr[27:25];
        if (op == 4'hF) begin
            mregs[ret_rd] = instr[15:0];
            ret_val   = instr[15:0];
            ret_alu   = 1'b0;
            ret_edge  = edge_n;
            free_edge = edge_n + 1;
        end else begin
            r = alu_fn(op, mregs[instr[24:22]], mregs[instr[21:19]]);
            mregs[ret_rd] = r[15:0];
            ret_val    = r[15:0];
            pend_flags = {r[16], (r[15:0] == 16'h0), ~^r[15:0]};
            ret_alu    = 1'b1;
            cur_op     = op;
            pop_e      = edge_n;
            ret_edge   = edge_n + 3;
            busy_until = edge_n + 3;
            free_edge  = edge_n + 4;
        end
    endtask

    task automatic model_edge();
        bit rdy_m;
        rdy_m = (pend.size() < FIFO_DEPTH);
        if (edge_n >= free_edge && pend.size() > 0) retire_model(pend.pop_front());
        if (instr_valid && rdy_m) begin
            pend.push_back(instr_data);
            void'(send_q.pop_front());
        end
    endtask

    task automatic checkCycle();
        bit exp_done;
        exp_done = (edge_n == ret_edge);
        if (!instr_ready) saw_ready_low = 1'b1;
        if (done) done_seen++;
        checkOutput("ready", instr_ready, pend.size() < FIFO_DEPTH);
        checkOutput("done", done, exp_done);
        checkOutput("busy", busy, (pend.size() > 0) || (edge_n < busy_until));
        if (ret_alu && edge_n >= pop_e && edge_n < ret_edge) checkOutput("alu_op_held", alu_op, cur_op);
        if (exp_done) begin
            if (ret_alu) begin
                mflags = pend_flags;
                checkOutput("alu_op_nop", alu_op, 4'hF);
            end
            checkOutput("flags", flags, mflags);
            dbg_addr = ret_rd;
            #1;
            checkOutput("wb_reg", dbg_data, ret_val);
        end
    endtask

    task automatic driveInputs();
        if (rand_mode && send_q.size() == 0 && $urandom_range(0, 2) != 0) send_q.push_back(rand_instr());
        if (send_q.size() > 0 && (!rand_mode || $urandom_range(0, 4) != 0)) begin
            instr_valid = 1'b1;
            instr_data  = send_q[0];
        end else begin
            instr_valid = 1'b0;
            instr_data  = $urandom;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        checkCycle();
        driveInputs();
    endtask

    task automatic drain();
        int k;
        k = 0;
        driveInputs();
        while (!(send_q.size() == 0 && pend.size() == 0 && edge_n >= ret_edge && edge_n >= busy_until) && k < 300) begin
            cycle();
            k++;
        end
        if (k >= 300) checkOutput("drain_timeout", 1, 0);
    endtask

    task automatic applyReset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        send_q.delete();
        pend.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        mflags     = 3'b000;
        ret_alu    = 1'b0;
        ret_edge   = -1;
        busy_until = -1;
        pop_e      = -1;
        free_edge  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic peekReg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        checkOutput(tag, dbg_data, exp);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int k;
        instr_data    = '0;
        dbg_addr      = '0;
        rand_mode     = 1'b0;
        saw_ready_low = 1'b0;
        applyReset();

        checkOutput("rst_alu_a", alu_a, 16'h0);
        checkOutput("rst_alu_b", alu_b, 16'h0);
        checkOutput("rst_alu_op", alu_op, 4'hF);
        checkOutput("rst_flags", flags, 3'b000);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", instr_ready, 1);

        $display("[TB] LDI/LDI/ADD");
        d0 = done_seen;
        applyStimulus(mk(4'hF, 3'd1, 3'd0, 3'd0, 16'h0005));
        applyStimulus(mk(4'hF, 3'd2, 3'd0, 3'd0, 16'h0003));
        applyStimulus(mk(4'h0, 3'd3, 3'd1, 3'd2, 16'h0000));
        drain();
        peekReg("add_r3", 3'd3, 16'h0008);
        checkOutput("add_flags", flags, 3'b000);
        checkOutput("add_done_cnt", done_seen - d0, 3);

        $display("[TB] SUB");
        applyStimulus(mk(4'h1, 3'd4, 3'd2, 3'd1, 16'h0000));
        drain();
        peekReg("sub_r4", 3'd4, 16'hFFFE);
        checkOutput("sub_flags", flags, 3'b100);

        $display("[TB] ADD with carry-out to zero");
        applyStimulus(mk(4'hF, 3'd5, 3'd0, 3'd0, 16'hFFFF));
        applyStimulus(mk(4'hF, 3'd6, 3'd0, 3'd0, 16'h0001));
        applyStimulus(mk(4'h0, 3'd7, 3'd5, 3'd6, 16'h0000));
        drain();
        peekReg("carry_r7", 3'd7, 16'h0000);
        checkOutput("carry_flags", flags, 3'b111);

        $display("[TB] six back-to-back ADDs from reset");
        applyReset();
        d0 = done_seen;
        saw_ready_low = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(mk(4'h0, 3'(i), 3'(i + 1), 3'(i + 2), 16'h0));
        drain();
        checkOutput("b2b_ready_low_seen", saw_ready_low, 1);
        checkOutput("b2b_done_cnt", done_seen - d0, 6);
        checkOutput("b2b_busy_low", busy, 0);

        $display("[TB] NOT with rd==rs1");
        applyStimulus(mk(4'hF, 3'd1, 3'd0, 3'd0, 16'h1234));
        applyStimulus(mk(4'h9, 3'd2, 3'd1, 3'd0, 16'h0000));
        applyStimulus(mk(4'h9, 3'd1, 3'd1, 3'd0, 16'h0000));
        drain();
        peekReg("not_r2", 3'd2, 16'hEDCB);
        peekReg("not_r1", 3'd1, 16'hEDCB);

        $display("[TB] reset during WB of SUB");
        applyReset();
        applyStimulus(mk(4'hF, 3'd1, 3'd0, 3'd0, 16'h0005));
        applyStimulus(mk(4'hF, 3'd2, 3'd0, 3'd0, 16'h0003));
        applyStimulus(mk(4'h1, 3'd4, 3'd2, 3'd1, 16'h0000));
        driveInputs();
        k = 0;
        while (!(ret_alu && edge_n == ret_edge - 2) && k < 50) begin
            cycle();
            k++;
        end
        if (k >= 50) checkOutput("wb_wait_timeout", 1, 0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_alu_op", alu_op, 4'hF);
        checkOutput("midrst_done", done, 0);
        applyReset();
        checkOutput("midrst_ready", instr_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_flags", flags, 3'b000);
        peekReg("midrst_r4", 3'd4, 16'h0000);
        d0 = done_seen;
        driveInputs();
        repeat (6) cycle();
        checkOutput("midrst_no_done", done_seen - d0, 0);

        $display("[TB] random traffic");
        rand_mode = 1'b1;
        repeat (400) cycle();
        rand_mode = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) peekReg("final_reg", 3'(i), mregs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
